// File: rtl/iis_tx_serializer.sv
// iis_tx_serializer: Philips I2S transmitter popping one FIFO word per channel slot
module iis_tx_serializer #(
  parameter int DATA_WIDTH = 16,
  parameter int CLK_DIV    = 4
) (
  input  logic                  i_clk_in,
  input  logic                  i_rst,
  input  logic                  i_en,
  input  logic                  i_clr_status,
  input  logic                  i_fifo_empty,
  input  logic                  i_fifo_vaild,
  input  logic [DATA_WIDTH-1:0] i_fifo_dout,
  output logic                  o_fifo_rden,
  output logic                  o_sck,
  output logic                  o_ws,
  output logic                  o_sd,
  output logic                  o_busy,
  output logic                  o_underrun,
  output logic [31:0]           o_send_num
);
  localparam int BW = $clog2(2 * DATA_WIDTH);
  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [BW-1:0] LAST    = BW'(2 * DATA_WIDTH - 1);
  localparam logic [BW-1:0] HALF    = BW'(DATA_WIDTH);
  localparam logic [BW-1:0] HALF_M1 = BW'(DATA_WIDTH - 1);
  localparam logic [DW-1:0] DIV_TOP = DW'(CLK_DIV - 1);
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  logic [1:0]            r_state;
  logic [DW-1:0]         r_div_cnt;
  logic [BW-1:0]         r_bit_cnt;
  logic [DATA_WIDTH-1:0] r_shift_reg;
  logic [DATA_WIDTH-1:0] r_next_word;
  logic                  r_fetch_ok;
  logic                  r_sck;
  logic                  r_ws;
  logic                  r_sd;
  logic                  r_fifo_rden;
  logic                  r_busy;
  logic                  r_underrun;
  logic [31:0]           r_send_num;

  logic                  w_wrap;
  logic                  w_fall;
  logic                  w_start;
  logic                  w_fetch;
  logic                  w_load;
  logic [BW-1:0]         w_nb;
  logic [DATA_WIDTH-1:0] w_load_val;

  assign w_wrap     = r_div_cnt == DIV_TOP;
  assign w_fall     = r_state != S_IDLE && w_wrap && r_sck;
  assign w_nb       = r_bit_cnt == LAST ? '0 : r_bit_cnt + 1'b1;
  assign w_load     = w_nb == '0 || w_nb == HALF;
  // a failed fetch leaves r_fetch_ok low so the next slot goes out as zeros
  assign w_load_val = r_fetch_ok ? r_next_word : '0;
  assign w_start    = r_state == S_IDLE && i_en && !i_fifo_empty;
  assign w_fetch    = w_start || (r_state == S_RUN && w_fall &&
                      (w_nb == HALF_M1 || (w_nb == LAST && i_en)));

  always_ff @(posedge i_clk_in or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_div_cnt   <= '0;
      r_bit_cnt   <= '0;
      r_shift_reg <= '0;
      r_next_word <= '0;
      r_fetch_ok  <= 1'b0;
      r_sck       <= 1'b0;
      r_ws        <= 1'b1;
      r_sd        <= 1'b0;
      r_fifo_rden <= 1'b0;
      r_busy      <= 1'b0;
      r_underrun  <= 1'b0;
      r_send_num  <= '0;
    end else begin
      r_fifo_rden <= w_fetch && !i_fifo_empty;
      if (w_fetch) r_fetch_ok <= !i_fifo_empty;
      if (i_fifo_vaild) r_next_word <= i_fifo_dout;
      r_underrun <= !i_clr_status && (r_underrun || (w_fetch && i_fifo_empty));
      r_send_num <= i_clr_status ? '0 : r_send_num + 32'(r_fifo_rden);
      if (w_start) begin
        r_state   <= S_RUN;
        r_busy    <= 1'b1;
        r_ws      <= 1'b0;
        r_bit_cnt <= LAST;
        r_div_cnt <= '0;
      end else if (r_state != S_IDLE) begin
        r_div_cnt <= w_wrap ? '0 : r_div_cnt + 1'b1;
        if (w_wrap) r_sck <= !r_sck;
        if (w_fall && r_state == S_DRAIN) begin
          r_sd    <= 1'b0;
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end else if (w_fall) begin
          r_bit_cnt   <= w_nb;
          r_sd        <= w_load ? w_load_val[DATA_WIDTH-1] : r_shift_reg[DATA_WIDTH-2];
          r_shift_reg <= w_load ? w_load_val : r_shift_reg << 1;
          if (w_nb == HALF_M1) r_ws <= 1'b1;
          if (w_nb == LAST) begin
            if (i_en) r_ws <= 1'b0;
            else r_state <= S_DRAIN;
          end
        end
      end
    end
  end

  assign o_fifo_rden = r_fifo_rden;
  assign o_sck       = r_sck;
  assign o_ws        = r_ws;
  assign o_sd        = r_sd;
  assign o_busy      = r_busy;
  assign o_underrun  = r_underrun;
  assign o_send_num  = r_send_num;
endmodule

// File: tb/tb_iis_tx_serializer.sv
// tb_iis_tx_serializer: directed frames against a zero-latency FIFO model and an sck-rise receiver
module tb_iis_tx_serializer;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic        clr = 1'b0;
  logic        fempty = 1'b1;
  logic        fvaild = 1'b0;
  logic [15:0] fdout = '0;
  logic        rden, sck, ws, sd, busy, urun;
  logic [31:0] snum;

  logic [15:0] fq[$];
  logic        sd_q[$];
  logic        ws_q[$];
  int          n_cmp = 0;
  int          n_err = 0;
  int          n_rden = 0;
  int          n_bad = 0;
  int          base = 0;
  int          k;
  logic        prev_sck = 1'b0;
  logic        seen;

  always #5 clk = ~clk;

  iis_tx_serializer #(.DATA_WIDTH(16), .CLK_DIV(2)) dut (
    .i_clk_in(clk), .i_rst(rst), .i_en(en), .i_clr_status(clr),
    .i_fifo_empty(fempty), .i_fifo_vaild(fvaild), .i_fifo_dout(fdout),
    .o_fifo_rden(rden), .o_sck(sck), .o_ws(ws), .o_sd(sd),
    .o_busy(busy), .o_underrun(urun), .o_send_num(snum)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
    fvaild = 1'b0;
    if (rden) begin
      n_rden++;
      if (fq.size() == 0) n_bad++;
      else begin
        fdout  = fq.pop_front();
        fvaild = 1'b1;
      end
    end
    fempty = fq.size() == 0;
    if (sck && !prev_sck) begin
      sd_q.push_back(sd);
      ws_q.push_back(ws);
    end
    prev_sck = sck;
  endtask

  task automatic push(input logic [15:0] w);
    fq.push_back(w);
    fempty = 1'b0;
  endtask

  task automatic do_rst();
    en  = 1'b0;
    rst = 1'b1;
    cyc();
    cyc();
    rst = 1'b0;
    sd_q.delete();
    ws_q.delete();
    base = n_rden;
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 400 && busy; i++) cyc();
    chk(tag, 32'(busy), 32'd0);
  endtask

  task automatic wait_bits(input string tag, input int n);
    for (int i = 0; i < 400 && sd_q.size() < n; i++) cyc();
    chk(tag, 32'(sd_q.size() >= n), 32'd1);
  endtask

  function automatic logic [31:0] word_at(input int s);
    logic [15:0] w = '0;
    for (int i = 0; i < 16; i++) w = {w[14:0], (s + i < sd_q.size()) ? sd_q[s + i] : 1'b0};
    return 32'(w);
  endfunction

  function automatic logic [31:0] ws_pat();
    logic [31:0] p = '0;
    for (int i = 1; i <= 32; i++) p = {p[30:0], (i < ws_q.size()) ? ws_q[i] : 1'b0};
    return p;
  endfunction

  task automatic chk_idle(input string tag);
    chk({tag, "_sck"}, 32'(sck), 32'd0);
    chk({tag, "_ws"}, 32'(ws), 32'd1);
    chk({tag, "_sd"}, 32'(sd), 32'd0);
  endtask

  initial begin
    cyc();
    chk("rst_sck", 32'(sck), 32'd0);
    chk("rst_ws", 32'(ws), 32'd1);
    chk("rst_sd", 32'(sd), 32'd0);
    chk("rst_rden", 32'(rden), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_urun", 32'(urun), 32'd0);
    chk("rst_snum", snum, 32'd0);

    do_rst();
    push(16'hA5F0);
    push(16'h1234);
    en = 1'b1;
    cyc();
    chk("t1_ws_fall", 32'(ws), 32'd0);
    chk("t1_busy", 32'(busy), 32'd1);
    for (k = 1; k < 20 && !sd; k++) cyc();
    chk("t1_msb_lat", 32'(k), 32'd5);
    en = 1'b0;
    wait_idle("t1_idle");
    chk("t1_left", word_at(1), 32'h0000A5F0);
    chk("t1_right", word_at(17), 32'h00001234);
    chk("t1_ws_pat", ws_pat(), 32'h0001FFFF);
    chk("t1_nbits", 32'(sd_q.size()), 32'd33);
    chk("t1_snum", snum, 32'd2);
    chk("t1_urun", 32'(urun), 32'd0);
    chk("t1_pops", 32'(n_rden - base), 32'd2);
    chk_idle("t1_end");

    do_rst();
    en   = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      cyc();
      seen = seen | busy | sck | !ws;
    end
    chk("t2_blocked", 32'(seen), 32'd0);
    chk("t2_no_pop", 32'(n_rden - base), 32'd0);
    push(16'h8001);
    push(16'h7FFE);
    cyc();
    chk("t2_start", 32'(busy), 32'd1);
    chk("t2_pop", 32'(n_rden - base), 32'd1);
    en = 1'b0;
    wait_idle("t2_idle");
    chk("t2_left", word_at(1), 32'h00008001);
    chk("t2_right", word_at(17), 32'h00007FFE);

    do_rst();
    push(16'hFFFF);
    en = 1'b1;
    wait_bits("t3_reach", 20);
    en = 1'b0;
    wait_idle("t3_idle");
    chk("t3_left", word_at(1), 32'h0000FFFF);
    chk("t3_right", word_at(17), 32'h00000000);
    chk("t3_urun", 32'(urun), 32'd1);
    chk("t3_snum", snum, 32'd1);
    chk("t3_pops", 32'(n_rden - base), 32'd1);
    chk("t3_bad_pop", 32'(n_bad), 32'd0);

    do_rst();
    push(16'h0F0F);
    push(16'hF0F0);
    push(16'h5555);
    en = 1'b1;
    wait_bits("t4_reach", 7);
    en = 1'b0;
    wait_idle("t4_idle");
    chk("t4_left", word_at(1), 32'h00000F0F);
    chk("t4_right", word_at(17), 32'h0000F0F0);
    chk("t4_ws_pat", ws_pat(), 32'h0001FFFF);
    chk("t4_pops", 32'(n_rden - base), 32'd2);
    chk("t4_fifo_left", 32'(fq.size()), 32'd1);
    chk_idle("t4_end");

    sd_q.delete();
    ws_q.delete();
    push(16'h2222);
    push(16'h3333);
    en = 1'b1;
    wait_bits("t5_reach", 26);
    rst = 1'b1;
    #1;
    chk_idle("t5_rst");
    chk("t5_snum", snum, 32'd0);
    chk("t5_urun", 32'(urun), 32'd0);
    chk("t5_busy", 32'(busy), 32'd0);
    cyc();
    cyc();
    sd_q.delete();
    ws_q.delete();
    push(16'h4444);
    base = n_rden;
    rst  = 1'b0;
    cyc();
    en = 1'b0;
    wait_idle("t5_idle");
    chk("t5_left", word_at(1), 32'h00003333);
    chk("t5_right", word_at(17), 32'h00004444);
    chk("t5_snum2", snum, 32'd2);

    do_rst();
    push(16'hAAAA);
    en = 1'b1;
    for (int i = 0; i < 300 && !urun; i++) cyc();
    chk("t6_urun_set", 32'(urun), 32'd1);
    for (int i = 1; i <= 8; i++) push(16'(i * 16'h0101));
    seen = 1'b0;
    for (int i = 0; i < 2000 && !seen; i++) begin
      cyc();
      if (rden && snum == 32'd7) begin
        clr = 1'b1;
        cyc();
        clr  = 1'b0;
        seen = 1'b1;
      end
    end
    chk("t6_clr_hit", 32'(seen), 32'd1);
    chk("t6_clr_snum", snum, 32'd0);
    chk("t6_clr_urun", 32'(urun), 32'd0);
    for (int i = 0; i < 300 && !rden; i++) cyc();
    cyc();
    chk("t6_next_snum", snum, 32'd1);
    en = 1'b0;
    wait_idle("t6_idle");
    chk("bad_pops", 32'(n_bad), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/iis_tx_serializer.md
Name: iis_tx_serializer

Overview:
Transmit-side I2S serializer that sits directly downstream of the 16-bit TX async FIFO. It pops one word per channel slot and generates the bit clock (sck), word select (ws) and serial data (sd) in Philips I2S format: MSB first, with ws changing one sck before each MSB. It reports busy, underrun and a running word count to the APB register block.

Parameters:
DATA_WIDTH, 16, bits per channel slot; equals the FIFO word width.
CLK_DIV, 4, clk_in cycles per sck half-period. Must be ≥2; sck period is 2*CLK_DIV.

Ports:
clk_in  input  1  system clock (pclk domain)
rst  input  1  asynchronous reset, active-high
en  input  1  transmit enable, level
clr_status  input  1  one-cycle pulse; clears underrun and send_num
fifo_empty  input  1  TX FIFO empty flag
fifo_vaild  input  1  high for one cycle when fifo_dout holds the popped word
fifo_dout  input  DATA_WIDTH  TX FIFO read data
fifo_rden  output  1  one-cycle pop request
sck  output  1  I2S bit clock
ws  output  1  word select; 0 = left, 1 = right
sd  output  1  serial data
busy  output  1  high while not IDLE
underrun  output  1  sticky; a slot was sent with no data
send_num  output  32  words taken from the FIFO and transmitted

Behaviour:
- Reset, and the IDLE state: sck=0, ws=1, sd=0, fifo_rden=0, busy=0, underrun=0, send_num=0.
- Reset also clears div_cnt, bit_cnt (0..2W-1, W=DATA_WIDTH), shift_reg and next_word.
- All outputs are registered. Any rst assertion mid-frame returns the block to reset values immediately; no partial frame completes.
- States: IDLE, RUN, DRAIN.
- IDLE -> RUN:
  - Trigger: en=1 and fifo_empty=0.
  - In the transition cycle: fifo_rden=1, ws<=0, bit_cnt<=2W-1, div_cnt<=0, sck stays 0.
- sck generation (RUN and DRAIN):
  - div_cnt counts 0..CLK_DIV-1; at CLK_DIV-1 it wraps and sck toggles.
  - A "fall event" is the cycle in which sck toggles 1->0. All sd, ws and bit_cnt updates occur only on fall events. The receiver samples on sck rise.
- On each fall event in RUN, with nb = (bit_cnt+1) mod 2W:
  - bit_cnt<=nb.
  - If nb==0 or nb==W: shift_reg<=next_word (or all-zero if the fetch failed), and sd<=MSB of that value.
  - Otherwise sd<=next bit of shift_reg, MSB first.
  - If nb==W-1: ws<=1 and a fetch is attempted.
  - If nb==2W-1 and en=1: ws<=0 and a fetch is attempted.
  - If nb==2W-1 and en=0: ws stays 1, no fetch, go to DRAIN.
- Fetch rules:
  - A fetch drives fifo_rden=1 for that single cycle, and only if fifo_empty=0.
  - next_word is captured on fifo_vaild.
  - If fifo_empty=1 at fetch time, no pop occurs, the following slot is transmitted as all-zero, and underrun<=1.
- DRAIN: at the next fall event, sd<=0, sck stays 0, ws stays 1, go to IDLE. The right-channel LSB therefore occupies a full sck period.
- en deasserted mid-frame: the current frame (left plus right) always completes. Stop granularity is one frame.
- send_num:
  - +1 on each successful fifo_rden whose word is loaded into shift_reg. Underrun slots do not count.
  - Wraps at 2^32.
- clr_status has priority over a same-cycle increment or underrun set; the register result is 0.
- Latency: en rise with a non-empty FIFO -> first MSB on sd at clk_in cycle 1+2*CLK_DIV after the transition cycle; ws is already low one full sck period earlier.
- FIFO timing contract: fifo_vaild must arrive within 2*CLK_DIV-1 cycles of fifo_rden. A synchronous 1-cycle-read FIFO meets this.

Test Plan:
- Nominal frame: CLK_DIV=2, FIFO holds 0xA5F0, 0x1234 -> one fifo_rden pulse per slot.
  - ws low for 16 sck (left), sd = 1010010111110000 MSB first starting one sck after the ws fall.
  - ws high, sd = 0001001000110100.
  - send_num=2, underrun=0.
- Start blocked: en=1 with fifo_empty=1 -> stays IDLE, busy=0, sck=0, ws=1, no fifo_rden for 100 cycles. Then push 0x8001 -> RUN starts next cycle.
- Underrun: FIFO holds only 0xFFFF, en held -> left slot = 16 ones, right slot = 16 zeros, underrun=1, send_num=1, fifo_rden never asserted while empty.
- Stop mid-frame: deassert en at left bit 5 -> frame completes through right LSB, DRAIN, then IDLE (sck=0, ws=1, sd=0, busy=0). No extra fetch at the final ws point.
- Reset mid-frame: assert rst during right bit 8 -> same cycle sck=0, ws=1, sd=0, send_num=0, underrun=0. After release with en=1, the first frame starts cleanly with the next FIFO word.
- clr_status: with send_num=7 and underrun=1, pulse clr_status coincident with a successful pop -> both read 0 next cycle; the next pop makes send_num=1.
